// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// FSM states: IDLE=line idle | START=start bit | DATA=data bits | PARITY=parity bit | STOP=stop bit(s)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE     = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO with wrap-bit pointers; pushes while full and
// pops while empty are ignored.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-buffered, runtime baud divisor, optional parity,
// 1/2 stop bits. Config is sampled per frame when the word is popped.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 odd_parity,
  input  logic                 two_stop,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_out
);

  localparam int                BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  state_t               state;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 par_q;
  logic                 pe_q;
  logic                 two_q;
  logic                 line;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign bit_end   = (cnt == div_q - 1'b1);
  assign last_stop = (stop_idx == two_q);
  // Pop on idle, or at the very end of a frame so the next one follows with no gap.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

  always_comb begin
    line = LINE_IDLE;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = par_q;
      default: line = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= DIV_W'(1);
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
      two_q    <= 1'b0;
      tx_out   <= LINE_IDLE;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_out  <= line;
      tx_done <= (state == STOP) && bit_end && last_stop;
      if (pop) begin
        shift   <= fifo_rdata;
        div_q   <= (baud_div == '0) ? DIV_W'(1) : baud_div;
        pe_q    <= parity_en;
        two_q   <= two_stop;
        par_q   <= calc_parity(MAX_DATA_BITS'(fifo_rdata), odd_parity);
        cnt     <= '0;
        state   <= START;
        tx_busy <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          START: begin
            if (bit_end) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else cnt <= cnt + 1'b1;
          end
          DATA: begin
            if (bit_end) begin
              cnt   <= '0;
              shift <= shift >> 1;
              if (bit_idx == LAST_BIT) begin
                stop_idx <= 1'b0;
                state    <= pe_q ? PARITY : STOP;
              end else bit_idx <= bit_idx + 1'b1;
            end else cnt <= cnt + 1'b1;
          end
          PARITY: begin
            if (bit_end) begin
              cnt      <= '0;
              stop_idx <= 1'b0;
              state    <= STOP;
            end else cnt <= cnt + 1'b1;
          end
          STOP: begin
            if (bit_end) begin
              cnt <= '0;
              if (last_stop) begin
                state   <= IDLE;
                tx_busy <= 1'b0;
              end else stop_idx <= 1'b1;
            end else cnt <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: line waveforms compared against a
// frame-level model built from the word and configuration.
module tb_uart_tx_param;

  localparam int DB = 8;
  localparam int FD = 4;
  localparam int DW = 16;
  localparam int CW = $clog2(FD+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] baud_div;
  logic          parity_en;
  logic          odd_parity;
  logic          two_stop;
  logic          wr_valid;
  logic [DB-1:0] wr_data;
  logic          wr_ready;
  logic [CW-1:0] fifo_count;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_out;

  int errors = 0;
  int checks = 0;

  logic exp_line[$];
  logic exp_done[$];
  logic obs_line[$];
  logic obs_done[$];

  logic [DB-1:0] bb_words[6];
  int            bb_idx;
  int            bb_guard;
  bit            bb_ok;

  uart_tx_param #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (FD),
    .DIV_W      (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .odd_parity (odd_parity),
    .two_stop   (two_stop),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_out     (tx_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: one frame as a list of bit levels, each held div cycles.
  function automatic void add_frame(input logic [DB-1:0] w, input int div,
                                    input bit pe, input bit odd, input bit two);
    int d;
    int ones;
    bit bits[$];
    d    = (div == 0) ? 1 : div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pe) bits.push_back(bit'((ones + (odd ? 1 : 0)) % 2));
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[b])
      for (int j = 0; j < d; j++) begin
        exp_line.push_back(bits[b]);
        exp_done.push_back(1'b0);
      end
    exp_done[exp_done.size()-1] = 1'b1;
  endfunction

  function automatic int mismatch_at();
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++)
      if (obs_line[i] !== exp_line[i] || obs_done[i] !== exp_done[i]) return i;
    return -1;
  endfunction

  task automatic clear_q();
    exp_line.delete(); exp_done.delete();
    obs_line.delete(); obs_done.delete();
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_line.push_back(tx_out);
      obs_done.push_back(tx_done);
    end
  endtask

  task automatic do_write(input logic [DB-1:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit odd, input bit two);
    baud_div   = DW'(div);
    parity_en  = pe;
    odd_parity = odd;
    two_stop   = two;
  endtask

  task automatic test_reset();
    int idle_bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_tx_out: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_tx_done: got %b want 0", tx_done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    rst = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || wr_ready !== 1'b1 ||
          fifo_count !== '0 || tx_done !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_100: %0d bad cycles, want 0", idle_bad); end
  endtask

  task automatic test_8n1();
    int d;
    set_cfg(4, 0, 0, 0);
    clear_q();
    add_frame(8'hA5, 4, 0, 0, 0);
    do_write(8'hA5);
    checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL 8n1_count_after_write: got %0d want 1", fifo_count); end
    @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL 8n1_latency: line got %b want 1 one cycle after write", tx_out); end
    checks++; if (tx_busy !== 1'b1 || fifo_count !== '0) begin errors++; $display("FAIL 8n1_popped: busy=%b count=%0d want busy=1 count=0", tx_busy, fifo_count); end
    capture(exp_line.size());
    d = mismatch_at();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL 8n1_frame: cycle %0d got line=%b done=%b want line=%b done=%b", d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
    repeat (3) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin errors++; $display("FAIL 8n1_back_idle: busy=%b line=%b want 0/1", tx_busy, tx_out); end
  endtask

  task automatic test_8o2();
    int d;
    set_cfg(3, 1, 1, 1);
    clear_q();
    add_frame(8'h03, 3, 1, 1, 1);
    do_write(8'h03);
    @(negedge clk);
    capture(exp_line.size());
    d = mismatch_at();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL 8o2_frame: cycle %0d got line=%b done=%b want line=%b done=%b", d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_frames();
    int d, div;
    bit pe, odd, two;
    logic [DB-1:0] w;
    for (int f = 0; f < 8; f++) begin
      div = (f == 0) ? 0 : int'($urandom_range(1, 5));
      pe  = bit'($urandom_range(0, 1));
      odd = bit'($urandom_range(0, 1));
      two = bit'($urandom_range(0, 1));
      w   = DB'($urandom);
      set_cfg(div, pe, odd, two);
      clear_q();
      add_frame(w, div, pe, odd, two);
      do_write(w);
      @(negedge clk);
      // Frame already latched its config; scrambling inputs now must not matter.
      set_cfg(int'($urandom_range(0, 9)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      capture(exp_line.size());
      d = mismatch_at();
      checks++;
      if (d >= 0) begin errors++; $display("FAIL rand_frame_%0d: cycle %0d got line=%b done=%b want line=%b done=%b", f, d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    set_cfg(2, 0, 0, 0);
    clear_q();
    for (int i = 0; i < 6; i++) begin
      bb_words[i] = DB'($urandom);
      add_frame(bb_words[i], 2, 0, 0, 0);
    end
    bb_idx   = 0;
    bb_guard = 0;
    wr_data  = bb_words[0];
    wr_valid = 1'b1;
    fork
      begin
        while (bb_idx < 6 && bb_guard < 400) begin
          bb_ok = wr_ready;
          @(posedge clk);
          @(negedge clk);
          bb_guard++;
          if (bb_ok) begin
            bb_idx++;
            if (bb_idx == 5) begin
              checks++;
              if (wr_ready !== 1'b0 || fifo_count !== CW'(4)) begin errors++; $display("FAIL b2b_full: ready=%b count=%0d want ready=0 count=4", wr_ready, fifo_count); end
            end
            if (bb_idx < 6) wr_data = bb_words[bb_idx];
            else wr_valid = 1'b0;
          end
        end
        wr_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        capture(exp_line.size());
      end
    join
    checks++;
    if (bb_idx != 6) begin errors++; $display("FAIL b2b_accepts: got %0d accepted want 6", bb_idx); end
    d = mismatch_at();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_stream: cycle %0d got line=%b done=%b want line=%b done=%b", d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
    repeat (3) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL b2b_drained: busy=%b count=%0d want 0/0", tx_busy, fifo_count); end
  endtask

  task automatic test_cfg_change();
    int d;
    bit odd_new;
    logic [DB-1:0] w0, w1;
    w0 = DB'($urandom);
    w1 = DB'($urandom);
    odd_new = bit'($urandom_range(0, 1));
    set_cfg(4, 0, 0, 0);
    clear_q();
    add_frame(w0, 4, 0, 0, 0);
    add_frame(w1, 8, 1, odd_new, 0);
    do_write(w0);
    do_write(w1);
    for (int i = 0; i < exp_line.size(); i++) begin
      @(negedge clk);
      obs_line.push_back(tx_out);
      obs_done.push_back(tx_done);
      if (i == 10) set_cfg(8, 1, odd_new, 0);
    end
    d = mismatch_at();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL cfg_change: cycle %0d got line=%b done=%b want line=%b done=%b", d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int d, bad;
    logic [DB-1:0] w0, w1, w2;
    w0 = DB'($urandom);
    w1 = DB'($urandom);
    w2 = DB'($urandom);
    set_cfg(4, 0, 0, 0);
    clear_q();
    add_frame(w0, 4, 0, 0, 0);
    do_write(w0);
    do_write(w1);
    bad = 0;
    // Line cycles 16..19 carry data bit 3; reset lands at the edge after sample 17.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (tx_out !== exp_line[i] || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_prefix: %0d bad cycles want 0", bad); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL rstmid_line: got %b want 1", tx_out); end
    checks++; if (fifo_count !== '0 || tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: count=%0d busy=%b want 0/0", fifo_count, tx_busy); end
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d bad cycles want 0", bad); end
    clear_q();
    add_frame(w2, 4, 0, 0, 0);
    do_write(w2);
    @(negedge clk);
    capture(exp_line.size());
    d = mismatch_at();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL rstmid_next_frame: cycle %0d got line=%b done=%b want line=%b done=%b", d, obs_line[d], obs_done[d], exp_line[d], exp_done[d]); end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    set_cfg(4, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_8n1();
    test_8o2();
    test_random_frames();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
